qutrit_op_scheduler: RTL
========================

# qutrit_op_scheduler

Sequencer and arbiter that shares one `qutrit_core` SU(3) rotation datapath between several requesters. Each requester submits a rotation job (operator code, Hamiltonian perturbation, repeat count). The scheduler grants jobs round-robin, drives the core's `q_op`/`h_input` for the requested number of cycles, waits for the Chern index to settle, then reports completion with the sampled `resonance_active` flag.

## Interface
- `NUM_REQ`, 4 — number of requesters, 2..8.
- `REP_W`, 4 — width of the per-job repeat count.
- `SETTLE`, 2 — idle cycles after the last issue before sampling resonance; minimum 2.
- `clk`  in  1  — single clock, rising edge.
- `reset`  in  1  — one clock; reset is asynchronous and active-high.
- `req_valid`  in  NUM_REQ  — job pending, one bit per requester.
- `req_ready`  out  NUM_REQ  — one-hot grant/accept.
- `req_op`  in  4*NUM_REQ  — operator code per requester; slice i is bits [4i+3:4i].
- `req_h`  in  32*NUM_REQ  — 16.16 Hamiltonian perturbation per requester.
- `req_rep`  in  REP_W*NUM_REQ  — issue cycles per requester; 0 is treated as 1.
- `resonance_active`  in  1  — from the core.
- `core_q_op`  out  4  — to core `q_op`; registered.
- `core_h_input`  out  32  — to core `h_input`; registered.
- `busy`  out  1  — state is not IDLE.
- `done`  out  1  — one-cycle completion pulse.
- `done_id`  out  $clog2(NUM_REQ)  — requester of the completed job.
- `done_resonance`  out  1  — sampled `resonance_active`.
- `done_err`  out  1  — job rejected because of an illegal op code.

## Operation
- **States:**
  - **IDLE:** core idle code 4'b0000 applies homeostasis damping.
  - **ISSUE:** drives the latched job.
  - **SETTLE:** waits for the Chern index.
  - **REPORT_ERR:** reports a rejected job.
- **Legal op codes:** 4'b0001 (λ1), 4'b0010 (λ4), 4'b0100 (λ8). Every other nonzero code, and 4'b0000, is illegal.
- **Arbitration:**
  - In IDLE, `req_ready` is combinational and one-hot: it selects the first `req_valid` bit searching from `last_grant+1`, modulo NUM_REQ.
  - `req_ready` is all zero outside IDLE and when no `req_valid` bit is set.
  - A handshake is `req_valid[i] && req_ready[i]` at a rising edge. At that edge the block latches op, h, rep (with 0 mapped to 1) and id, and sets `last_grant = i`.
- **IDLE → ISSUE** on a handshake with a legal op:
  - `core_q_op` takes the latched op and `core_h_input` takes the latched h at that same edge.
  - The repeat counter is loaded with rep.
- **IDLE → REPORT_ERR** on a handshake with an illegal op. Core outputs stay 0.
- **ISSUE:** the counter decrements once per cycle. On the edge where it reaches 0:
  - `core_q_op` and `core_h_input` return to 0;
  - the state moves to SETTLE with the settle counter = SETTLE.
- **SETTLE:** the counter decrements once per cycle. On the edge where it reaches 0, the block registers:
  - `done=1`;
  - `done_id`;
  - `done_resonance = resonance_active`;
  - `done_err=0`;
  - state → IDLE.
- **REPORT_ERR:** on the next edge, `done=1`, `done_err=1`, `done_resonance=0`, state → IDLE.
- **Donor-held fields:** `done_id`, `done_resonance` and `done_err` hold their values until the next done pulse. `done` is high for exactly one cycle.
- **Request inputs:** are ignored while busy. Requesters must hold `req_valid` and the payload stable until the handshake.
- **Reset (any time, including mid-ISSUE):**
  - state = IDLE, `core_q_op=0`, `core_h_input=0`;
  - `done`, `done_err`, `done_resonance` = 0, `done_id=0`;
  - `last_grant = NUM_REQ-1`, so requester 0 wins first;
  - counters = 0;
  - any in-flight job is dropped without a done pulse.

## Timing
- **Legal job:** handshake at edge E.
  - `core_q_op` = op during cycles [E, E+rep) and 0 from E+rep.
  - The core updates lambda at edges E+1..E+rep and chern_index at E+rep+1.
  - `resonance_active` is sampled at E+rep+SETTLE. `done` is high during the cycle starting at E+rep+SETTLE.
  - The block is in IDLE from that same edge, so the next handshake can occur at E+rep+SETTLE+1.
  - Job-to-job throughput: rep+SETTLE+1 cycles.
- **Illegal job:** handshake at E; `done`/`done_err` are high during the cycle starting at E+1; the next handshake can occur at E+2.
- **`busy`:** registered, high from E until the edge that raises `done`.
- **Simultaneous requests:** only one grant per handshake edge. Losing requesters keep waiting.

## Test plan
- **Reset:** assert reset mid-cycle with no clock → every output is 0 and `req_ready` = 0 with no `req_valid`. After release, req0 and req2 valid → `req_ready` = 4'b0001.
- **Single legal job:** req1 with op=4'b0001, h=32'h00020000, rep=3, handshake at E → `core_q_op`=1 and `core_h_input`=32'h00020000 for exactly 3 cycles. With SETTLE=2: `done` at E+5, `done_id`=1, `done_resonance` = the core's value.
- **Round-robin:** all four requesters valid and held → grants in order 0,1,2,3,0. Each job has rep=1, so consecutive handshakes are 4 cycles apart.
- **Repeat count zero:** rep=0 with op=4'b0100 → exactly one issue cycle, `done` at E+3.
- **Illegal op:** req3 with op=4'b0011 → `core_q_op` stays 0, `done_err`=1 and `done_id`=3 at E+1, next grant possible at E+2.
- **Reset mid-ISSUE:** rep=15, reset asserted at cycle E+4 → `core_q_op`=0 immediately, no done pulse, and the next grant goes to requester 0.

Source files
------------

// File: rtl/qutrit_op_scheduler.sv
// Round-robin job scheduler sharing one qutrit_core rotation datapath.
// Grants a requester, drives q_op/h_input for rep cycles, waits SETTLE cycles, then reports.
module qutrit_op_scheduler #(
    parameter int NUM_REQ = 4,
    parameter int REP_W   = 4,
    parameter int SETTLE  = 2
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [NUM_REQ-1:0]         req_valid,
    output logic [NUM_REQ-1:0]         req_ready,
    input  logic [4*NUM_REQ-1:0]       req_op,
    input  logic [32*NUM_REQ-1:0]      req_h,
    input  logic [REP_W*NUM_REQ-1:0]   req_rep,
    input  logic                       resonance_active,
    output logic [3:0]                 core_q_op,
    output logic [31:0]                core_h_input,
    output logic                       busy,
    output logic                       done,
    output logic [$clog2(NUM_REQ)-1:0] done_id,
    output logic                       done_resonance,
    output logic                       done_err
);
    localparam int ID_W  = $clog2(NUM_REQ);
    localparam int SET_W = $clog2(SETTLE + 1);
    localparam int CNT_W = (REP_W > SET_W) ? REP_W : SET_W;
    localparam logic [ID_W:0] NREQ = (ID_W + 1)'(NUM_REQ);

    typedef enum logic [1:0] {ST_IDLE, ST_ISSUE, ST_SETTLE, ST_REPORT_ERR} state_t;

    state_t            state_reg, state_next;
    logic [CNT_W-1:0]  cnt_reg, cnt_next;
    logic [3:0]        q_op_reg, q_op_next;
    logic [31:0]       h_reg, h_next;
    logic [ID_W-1:0]   job_id_reg, job_id_next;
    logic [ID_W-1:0]   last_grant_reg, last_grant_next;
    logic              done_reg, done_next;
    logic [ID_W-1:0]   done_id_reg, done_id_next;
    logic              done_res_reg, done_res_next;
    logic              done_err_reg, done_err_next;

    logic [3:0]        op_arr  [NUM_REQ];
    logic [31:0]       h_arr   [NUM_REQ];
    logic [REP_W-1:0]  rep_arr [NUM_REQ];

    genvar gi;
    generate
        for (gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
            assign op_arr[gi]  = req_op[4*gi +: 4];
            assign h_arr[gi]   = req_h[32*gi +: 32];
            assign rep_arr[gi] = req_rep[REP_W*gi +: REP_W];
        end
    endgenerate

    // Rotating priority: first valid requester after the last one granted.
    logic [ID_W-1:0] sel;
    logic            found;
    logic [ID_W:0]   cand;
    always_comb begin
        sel   = '0;
        found = 1'b0;
        cand  = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            cand = {1'b0, last_grant_reg} + k[ID_W:0];
            if (cand >= NREQ) cand = cand - NREQ;
            if (!found && req_valid[cand[ID_W-1:0]]) begin
                found = 1'b1;
                sel   = cand[ID_W-1:0];
            end
        end
    end

    logic             grant;
    logic [3:0]       op_sel;
    logic [31:0]      h_sel;
    logic [REP_W-1:0] rep_sel;
    logic             op_legal;
    logic [CNT_W-1:0] rep_load;

    assign grant     = (state_reg == ST_IDLE) && found;
    assign req_ready = grant ? (NUM_REQ'(1) << sel) : '0;
    assign op_sel    = op_arr[sel];
    assign h_sel     = h_arr[sel];
    assign rep_sel   = rep_arr[sel];
    assign op_legal  = (op_sel == 4'b0001) || (op_sel == 4'b0010) || (op_sel == 4'b0100);
    assign rep_load  = (rep_sel == '0) ? CNT_W'(1) : CNT_W'(rep_sel);

    always_comb begin
        state_next      = state_reg;
        cnt_next        = cnt_reg;
        q_op_next       = q_op_reg;
        h_next          = h_reg;
        job_id_next     = job_id_reg;
        last_grant_next = last_grant_reg;
        done_next       = 1'b0;
        done_id_next    = done_id_reg;
        done_res_next   = done_res_reg;
        done_err_next   = done_err_reg;
        case (state_reg)
            ST_IDLE: begin
                if (grant) begin
                    last_grant_next = sel;
                    job_id_next     = sel;
                    if (op_legal) begin
                        q_op_next  = op_sel;
                        h_next     = h_sel;
                        cnt_next   = rep_load;
                        state_next = ST_ISSUE;
                    end else begin
                        state_next = ST_REPORT_ERR;
                    end
                end
            end
            ST_ISSUE: begin
                if (cnt_reg <= CNT_W'(1)) begin
                    q_op_next  = 4'b0000;
                    h_next     = 32'h0;
                    cnt_next   = CNT_W'(SETTLE);
                    state_next = ST_SETTLE;
                end else begin
                    cnt_next = cnt_reg - CNT_W'(1);
                end
            end
            ST_SETTLE: begin
                if (cnt_reg <= CNT_W'(1)) begin
                    cnt_next      = '0;
                    done_next     = 1'b1;
                    done_id_next  = job_id_reg;
                    done_res_next = resonance_active;
                    done_err_next = 1'b0;
                    state_next    = ST_IDLE;
                end else begin
                    cnt_next = cnt_reg - CNT_W'(1);
                end
            end
            default: begin
                done_next     = 1'b1;
                done_id_next  = job_id_reg;
                done_res_next = 1'b0;
                done_err_next = 1'b1;
                state_next    = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg      <= ST_IDLE;
            cnt_reg        <= '0;
            q_op_reg       <= 4'b0000;
            h_reg          <= 32'h0;
            job_id_reg     <= '0;
            last_grant_reg <= ID_W'(NUM_REQ - 1);
            done_reg       <= 1'b0;
            done_id_reg    <= '0;
            done_res_reg   <= 1'b0;
            done_err_reg   <= 1'b0;
        end else begin
            state_reg      <= state_next;
            cnt_reg        <= cnt_next;
            q_op_reg       <= q_op_next;
            h_reg          <= h_next;
            job_id_reg     <= job_id_next;
            last_grant_reg <= last_grant_next;
            done_reg       <= done_next;
            done_id_reg    <= done_id_next;
            done_res_reg   <= done_res_next;
            done_err_reg   <= done_err_next;
        end
    end

    assign core_q_op      = q_op_reg;
    assign core_h_input   = h_reg;
    assign busy           = (state_reg != ST_IDLE);
    assign done           = done_reg;
    assign done_id        = done_id_reg;
    assign done_resonance = done_res_reg;
    assign done_err       = done_err_reg;
endmodule
